// File: rtl/mmu_ext_mem_master_if.sv
// Signal bundle for mmu_ext_mem_master: MMU line request/response plus the
// external-memory burst port. master = the block itself, slave = its environment.
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif

interface mmu_ext_mem_master_if #(
    parameter int PADDR_W = `PHY_ADDR_WIDTH
);
    logic               i_req_vld;
    logic               o_req_rdy;
    logic               i_req_wr;
    logic [PADDR_W-1:0] i_req_paddr;
    logic [2:0]         i_req_beats;
    logic [511:0]       i_req_wdat;
    logic [63:0]        i_req_mask;
    logic               o_rsp_vld;
    logic               o_rsp_wr;
    logic               o_rsp_err;
    logic [511:0]       o_rsp_rdat;
    logic               o_mem_ext_rden;
    logic               o_mem_ext_wren;
    logic [2:0]         o_mem_ext_burst_size;
    logic [PADDR_W-1:0] o_mem_ext_paddr;
    logic [127:0]       o_mem_ext_wdat;
    logic [15:0]        o_mem_ext_mask;
    logic               o_mem_ext_burst_start;
    logic               o_mem_ext_burst_end;
    logic               o_mem_ext_burst_vld;
    logic               i_ext_mmu_rdy;
    logic               i_ext_mmu_rd_ack;
    logic               i_ext_mmu_wr_ack;
    logic [127:0]       i_ext_mmu_rdat;

    modport master (
        input  i_req_vld, i_req_wr, i_req_paddr, i_req_beats, i_req_wdat, i_req_mask,
        input  i_ext_mmu_rdy, i_ext_mmu_rd_ack, i_ext_mmu_wr_ack, i_ext_mmu_rdat,
        output o_req_rdy, o_rsp_vld, o_rsp_wr, o_rsp_err, o_rsp_rdat,
        output o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_burst_size, o_mem_ext_paddr,
        output o_mem_ext_wdat, o_mem_ext_mask, o_mem_ext_burst_start, o_mem_ext_burst_end,
        output o_mem_ext_burst_vld
    );

    modport slave (
        output i_req_vld, i_req_wr, i_req_paddr, i_req_beats, i_req_wdat, i_req_mask,
        output i_ext_mmu_rdy, i_ext_mmu_rd_ack, i_ext_mmu_wr_ack, i_ext_mmu_rdat,
        input  o_req_rdy, o_rsp_vld, o_rsp_wr, o_rsp_err, o_rsp_rdat,
        input  o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_burst_size, o_mem_ext_paddr,
        input  o_mem_ext_wdat, o_mem_ext_mask, o_mem_ext_burst_start, o_mem_ext_burst_end,
        input  o_mem_ext_burst_vld
    );
endinterface

// File: rtl/mmu_ext_mem_master.sv
// MMU-side burst initiator: splits a 512-bit line read/write into 1..4 beats of 128 bits,
// reassembles read beats, and returns one response per request (with ack timeout).
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif

module mmu_ext_mem_master #(
    parameter int PADDR_W     = `PHY_ADDR_WIDTH,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mmu_ext_mem_master_if.master bus
);
    localparam int NUM_BEATS = 4;
    localparam int BEAT_W    = 128;
    localparam int MASK_W    = BEAT_W / 8;

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, WR_BEAT, RD_BEAT, RD_LAST, WR_WAIT, RD_WAIT, RESP
    } state_t;

    typedef struct packed {
        logic                                wr;
        logic [2:0]                          beats;
        logic [PADDR_W-1:0]                  paddr;
        logic [NUM_BEATS-1:0][BEAT_W-1:0]    wdat;
        logic [NUM_BEATS-1:0][MASK_W-1:0]    mask;
    } req_t;

    typedef struct packed {
        logic                                wr;
        logic                                err;
        logic [NUM_BEATS-1:0][BEAT_W-1:0]    rdat;
    } rsp_t;

    state_t                           state, state_nxt;
    req_t                             req_q;
    rsp_t                             rsp_q;
    logic [NUM_BEATS-1:0][BEAT_W-1:0] line_buf, line_nxt;
    logic [1:0]                       beat_cnt;
    logic [7:0]                       tmo_cnt;
    logic [2:0]                       beats_norm;
    logic [1:0]                       last_idx;
    logic                             accept, last_beat, in_beat, in_burst, in_wait;
    logic                             tmo_hit, tmo_exit, rsp_load;

    assign accept     = (state == IDLE) && bus.i_req_vld;
    assign beats_norm = (bus.i_req_beats == 3'd0 || bus.i_req_beats > 3'd4) ? 3'd4 : bus.i_req_beats;
    assign in_beat    = (state == WR_BEAT) || (state == RD_BEAT);
    assign in_burst   = in_beat || (state == RD_LAST);
    assign in_wait    = (state == WR_WAIT) || (state == RD_WAIT);
    assign last_beat  = ({1'b0, beat_cnt} == (req_q.beats - 3'd1));
    assign last_idx   = req_q.beats[1:0] - 2'd1;
    assign tmo_hit    = (tmo_cnt == 8'(TIMEOUT_CYC - 1));
    assign tmo_exit   = ((state == WR_WAIT) && !bus.i_ext_mmu_wr_ack) ||
                        ((state == RD_WAIT) && !bus.i_ext_mmu_rd_ack);
    assign rsp_load   = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt                 = state;
        bus.o_req_rdy             = (state == IDLE);
        bus.o_rsp_vld             = (state == RESP);
        bus.o_rsp_wr              = rsp_q.wr;
        bus.o_rsp_err             = rsp_q.err;
        bus.o_rsp_rdat            = rsp_q.rdat;
        bus.o_mem_ext_rden        = 1'b0;
        bus.o_mem_ext_wren        = 1'b0;
        bus.o_mem_ext_burst_start = 1'b0;
        bus.o_mem_ext_burst_end   = 1'b0;
        bus.o_mem_ext_burst_vld   = in_beat;
        bus.o_mem_ext_burst_size  = in_burst ? req_q.beats : 3'd0;
        bus.o_mem_ext_paddr       = in_burst ? req_q.paddr : '0;
        bus.o_mem_ext_wdat        = '0;
        bus.o_mem_ext_mask        = '0;
        unique case (state)
            IDLE:     if (accept) state_nxt = WAIT_RDY;
            WAIT_RDY: if (bus.i_ext_mmu_rdy) state_nxt = req_q.wr ? WR_BEAT : RD_BEAT;
            WR_BEAT: begin
                bus.o_mem_ext_wren        = (beat_cnt == 2'd0);
                bus.o_mem_ext_burst_start = (beat_cnt == 2'd0);
                bus.o_mem_ext_burst_end   = last_beat;
                bus.o_mem_ext_wdat        = req_q.wdat[beat_cnt];
                bus.o_mem_ext_mask        = req_q.mask[beat_cnt];
                if (last_beat) state_nxt = bus.i_ext_mmu_wr_ack ? RESP : WR_WAIT;
            end
            RD_BEAT: begin
                bus.o_mem_ext_rden        = (beat_cnt == 2'd0);
                bus.o_mem_ext_burst_start = (beat_cnt == 2'd0);
                if (last_beat) state_nxt = RD_LAST;
            end
            // read data trails the command by one cycle, so the final beat lands here
            RD_LAST: begin
                bus.o_mem_ext_burst_end = 1'b1;
                state_nxt = bus.i_ext_mmu_rd_ack ? RESP : RD_WAIT;
            end
            WR_WAIT: if (bus.i_ext_mmu_wr_ack || tmo_hit) state_nxt = RESP;
            RD_WAIT: if (bus.i_ext_mmu_rd_ack || tmo_hit) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        line_nxt = line_buf;
        if (accept && !bus.i_req_wr) line_nxt = '0;
        if (state == RD_BEAT && beat_cnt != 2'd0) line_nxt[beat_cnt - 2'd1] = bus.i_ext_mmu_rdat;
        if (state == RD_LAST) line_nxt[last_idx] = bus.i_ext_mmu_rdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            rsp_q    <= '0;
            line_buf <= '0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            line_buf <= line_nxt;
            beat_cnt <= (in_beat && !last_beat) ? beat_cnt + 2'd1 : 2'd0;
            tmo_cnt  <= in_wait ? tmo_cnt + 8'd1 : 8'd0;
            if (accept) begin
                req_q.wr    <= bus.i_req_wr;
                req_q.beats <= beats_norm;
                req_q.paddr <= bus.i_req_paddr;
                req_q.wdat  <= bus.i_req_wdat;
                req_q.mask  <= bus.i_req_mask;
            end
            // capture from line_nxt so an ack in the final read cycle keeps the last beat
            if (rsp_load) begin
                rsp_q.wr   <= req_q.wr;
                rsp_q.err  <= tmo_exit;
                rsp_q.rdat <= req_q.wr ? '0 : line_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mmu_ext_mem_master.sv
// Directed bench for mmu_ext_mem_master: write/read bursts, short and defaulted
// bursts, rdy stall, ack timeout and reset in the middle of a read burst.
module tb_mmu_ext_mem_master;
    localparam int PADDR_W     = 40;
    localparam int TIMEOUT_CYC = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mmu_ext_mem_master_if #(.PADDR_W(PADDR_W)) bus ();

    mmu_ext_mem_master #(.PADDR_W(PADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {burst_vld, burst_start, burst_end, wren, rden}
    logic [4:0] ctl;
    assign ctl = {bus.o_mem_ext_burst_vld, bus.o_mem_ext_burst_start, bus.o_mem_ext_burst_end,
                  bus.o_mem_ext_wren, bus.o_mem_ext_rden};

    logic [127:0] pa [4] = '{128'hA0A0A0A0_00000000_11111111_A0A0A0A0, 128'hA1A1A1A1_22222222_33333333_A1A1A1A1,
                             128'hA2A2A2A2_44444444_55555555_A2A2A2A2, 128'hA3A3A3A3_66666666_77777777_A3A3A3A3};
    logic [127:0] pb [4] = '{128'hB0B0B0B0_DEADBEEF_00000000_000000B0, 128'hB1B1B1B1_CAFEF00D_11111111_000000B1,
                             128'hB2B2B2B2_01234567_22222222_000000B2, 128'hB3B3B3B3_89ABCDEF_33333333_000000B3};
    logic [127:0] pc [2] = '{128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C0C0C0, 128'hC1C1C1C1_00000000_FFFFFFFF_C1C1C1C1};

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [PADDR_W-1:0] a, input logic [2:0] n,
                         input logic [511:0] wd, input logic [63:0] m);
        bus.i_req_vld   = 1'b1;
        bus.i_req_wr    = wr;
        bus.i_req_paddr = a;
        bus.i_req_beats = n;
        bus.i_req_wdat  = wd;
        bus.i_req_mask  = m;
        cyc();
        bus.i_req_vld   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        n_chk++; if (bus.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_req_rdy: got %b expected 1", bus.o_req_rdy); end
        n_chk++; if (ctl !== 5'b00000) begin n_fail++; $display("FAIL rst_ctl: got %b expected 00000", ctl); end
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b000) begin n_fail++; $display("FAIL rst_rsp: got %b expected 000", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}); end
        n_chk++; if (bus.o_rsp_rdat !== 512'd0) begin n_fail++; $display("FAIL rst_rdat: got %h expected 0", bus.o_rsp_rdat); end
        n_chk++; if ({bus.o_mem_ext_burst_size, bus.o_mem_ext_paddr, bus.o_mem_ext_wdat, bus.o_mem_ext_mask} !== 187'd0) begin n_fail++; $display("FAIL rst_bus: nonzero burst fields size=%0d paddr=%h", bus.o_mem_ext_burst_size, bus.o_mem_ext_paddr); end
        rst_n = 1'b1;
        cyc();
        n_chk++; if (bus.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_release_rdy: got %b expected 1", bus.o_req_rdy); end
    endtask

    task automatic test_write_burst();
        logic [511:0] wd;
        logic [4:0]   exp;
        wd = {pa[3], pa[2], pa[1], pa[0]};
        issue(1'b1, 40'h1000, 3'd4, wd, '1);
        n_chk++; if (bus.o_req_rdy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_rdy: got %b expected 0", bus.o_req_rdy); end
        cyc();
        for (int k = 0; k < 4; k++) begin
            exp = {1'b1, (k == 0), (k == 3), (k == 0), 1'b0};
            n_chk++; if (ctl !== exp) begin n_fail++; $display("FAIL wr_ctl k=%0d: got %b expected %b", k, ctl, exp); end
            n_chk++; if (bus.o_mem_ext_wdat !== pa[k] || bus.o_mem_ext_mask !== 16'hFFFF) begin n_fail++; $display("FAIL wr_beat k=%0d: got %h/%h expected %h/ffff", k, bus.o_mem_ext_wdat, bus.o_mem_ext_mask, pa[k]); end
            n_chk++; if (bus.o_mem_ext_paddr !== 40'h1000 || bus.o_mem_ext_burst_size !== 3'd4) begin n_fail++; $display("FAIL wr_addr k=%0d: got %h/%0d expected 1000/4", k, bus.o_mem_ext_paddr, bus.o_mem_ext_burst_size); end
            cyc();
        end
        n_chk++; if (ctl !== 5'b00000 || bus.o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL wr_wait: got ctl=%b rsp_vld=%b expected 00000/0", ctl, bus.o_rsp_vld); end
        cyc();
        bus.i_ext_mmu_wr_ack = 1'b1;
        cyc();
        bus.i_ext_mmu_wr_ack = 1'b0;
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b110) begin n_fail++; $display("FAIL wr_rsp: got %b expected 110", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}); end
        cyc();
        n_chk++; if (bus.o_rsp_vld !== 1'b0 || bus.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_after: got rsp_vld=%b rdy=%b expected 0/1", bus.o_rsp_vld, bus.o_req_rdy); end
    endtask

    task automatic test_read_burst();
        logic [511:0] exp_line;
        logic [4:0]   exp;
        int           rden_cnt;
        exp_line = {pb[3], pb[2], pb[1], pb[0]};
        rden_cnt = 0;
        issue(1'b0, 40'h2040, 3'd4, '0, '0);
        rden_cnt += int'(bus.o_mem_ext_rden);
        cyc();
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) bus.i_ext_mmu_rdat = pb[k-1];
            exp = {1'b1, (k == 0), 1'b0, 1'b0, (k == 0)};
            n_chk++; if (ctl !== exp) begin n_fail++; $display("FAIL rd_ctl k=%0d: got %b expected %b", k, ctl, exp); end
            rden_cnt += int'(bus.o_mem_ext_rden);
            cyc();
        end
        bus.i_ext_mmu_rdat = pb[3];
        n_chk++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL rd_end: got %b expected 00100", ctl); end
        rden_cnt += int'(bus.o_mem_ext_rden);
        cyc();
        bus.i_ext_mmu_rdat = '0;
        bus.i_ext_mmu_rd_ack = 1'b1;
        rden_cnt += int'(bus.o_mem_ext_rden);
        cyc();
        bus.i_ext_mmu_rd_ack = 1'b0;
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b100) begin n_fail++; $display("FAIL rd_rsp: got %b expected 100", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}); end
        n_chk++; if (bus.o_rsp_rdat !== exp_line) begin n_fail++; $display("FAIL rd_line: got %h expected %h", bus.o_rsp_rdat, exp_line); end
        cyc();
        n_chk++; if (bus.o_rsp_vld !== 1'b0 || bus.o_rsp_rdat !== exp_line) begin n_fail++; $display("FAIL rd_hold: got rsp_vld=%b rdat=%h expected 0/%h", bus.o_rsp_vld, bus.o_rsp_rdat, exp_line); end
        n_chk++; if (rden_cnt !== 1) begin n_fail++; $display("FAIL rd_rden_count: got %0d expected 1", rden_cnt); end
    endtask

    task automatic test_short_and_default();
        logic [511:0] wd;
        logic [63:0]  m;
        logic [4:0]   exp;
        issue(1'b0, 40'h3000, 3'd1, '0, '0);
        cyc();
        n_chk++; if (ctl !== 5'b11001 || bus.o_mem_ext_burst_size !== 3'd1) begin n_fail++; $display("FAIL rd1_start: got ctl=%b size=%0d expected 11001/1", ctl, bus.o_mem_ext_burst_size); end
        cyc();
        bus.i_ext_mmu_rdat = pc[0];
        n_chk++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL rd1_end: got %b expected 00100", ctl); end
        cyc();
        bus.i_ext_mmu_rdat = '0;
        bus.i_ext_mmu_rd_ack = 1'b1;
        cyc();
        bus.i_ext_mmu_rd_ack = 1'b0;
        n_chk++; if (bus.o_rsp_vld !== 1'b1 || bus.o_rsp_rdat !== {384'd0, pc[0]}) begin n_fail++; $display("FAIL rd1_line: got vld=%b rdat=%h expected 1/%h", bus.o_rsp_vld, bus.o_rsp_rdat, {384'd0, pc[0]}); end
        cyc();
        wd = {pa[0], pa[1], pa[2], pa[3]};
        m  = 64'h0123_4567_89AB_CDEF;
        issue(1'b1, 40'h4000, 3'd0, wd, m);
        cyc();
        for (int k = 0; k < 4; k++) begin
            exp = {1'b1, (k == 0), (k == 3), (k == 0), 1'b0};
            n_chk++; if (ctl !== exp || bus.o_mem_ext_burst_size !== 3'd4) begin n_fail++; $display("FAIL wr0_ctl k=%0d: got %b/%0d expected %b/4", k, ctl, bus.o_mem_ext_burst_size, exp); end
            n_chk++; if (bus.o_mem_ext_mask !== m[16*k +: 16] || bus.o_mem_ext_wdat !== pa[3-k]) begin n_fail++; $display("FAIL wr0_beat k=%0d: got %h/%h expected %h/%h", k, bus.o_mem_ext_mask, bus.o_mem_ext_wdat, m[16*k +: 16], pa[3-k]); end
            if (k == 3) bus.i_ext_mmu_wr_ack = 1'b1;
            cyc();
        end
        bus.i_ext_mmu_wr_ack = 1'b0;
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b110) begin n_fail++; $display("FAIL wr0_early_ack: got %b expected 110", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}); end
        cyc();
    endtask

    task automatic test_rdy_stall();
        bus.i_ext_mmu_rdy = 1'b0;
        issue(1'b1, 40'h5000, 3'd2, {256'd0, pa[1], pa[0]}, '1);
        for (int i = 0; i < 10; i++) begin
            n_chk++; if (ctl !== 5'b00000 || bus.o_req_rdy !== 1'b0) begin n_fail++; $display("FAIL stall i=%0d: got ctl=%b rdy=%b expected 00000/0", i, ctl, bus.o_req_rdy); end
            bus.i_req_vld   = (i % 2 == 0);
            bus.i_req_wr    = 1'b0;
            bus.i_req_paddr = 40'hDEAD0;
            bus.i_req_beats = 3'd1;
            cyc();
        end
        bus.i_req_vld = 1'b0;
        bus.i_ext_mmu_rdy = 1'b1;
        cyc();
        n_chk++; if (ctl !== 5'b11010 || bus.o_mem_ext_paddr !== 40'h5000 || bus.o_mem_ext_burst_size !== 3'd2) begin n_fail++; $display("FAIL stall_start: got ctl=%b paddr=%h size=%0d expected 11010/5000/2", ctl, bus.o_mem_ext_paddr, bus.o_mem_ext_burst_size); end
        n_chk++; if (bus.o_mem_ext_wdat !== pa[0]) begin n_fail++; $display("FAIL stall_beat0: got %h expected %h", bus.o_mem_ext_wdat, pa[0]); end
        cyc();
        n_chk++; if (ctl !== 5'b10100 || bus.o_mem_ext_wdat !== pa[1]) begin n_fail++; $display("FAIL stall_beat1: got ctl=%b wdat=%h expected 10100/%h", ctl, bus.o_mem_ext_wdat, pa[1]); end
        cyc();
        bus.i_ext_mmu_wr_ack = 1'b1;
        cyc();
        bus.i_ext_mmu_wr_ack = 1'b0;
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b110) begin n_fail++; $display("FAIL stall_rsp: got %b expected 110", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}); end
        cyc();
    endtask

    task automatic test_timeout();
        int cnt;
        issue(1'b1, 40'h6000, 3'd1, {384'd0, pa[2]}, '1);
        cyc();
        n_chk++; if (ctl !== 5'b11110) begin n_fail++; $display("FAIL tmo_single_beat: got %b expected 11110", ctl); end
        cyc();
        bus.i_ext_mmu_rd_ack = 1'b1;
        cnt = 0;
        while (bus.o_rsp_vld !== 1'b1 && cnt < 400) begin
            cyc();
            cnt++;
        end
        bus.i_ext_mmu_rd_ack = 1'b0;
        n_chk++; if (cnt !== TIMEOUT_CYC) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected %0d", cnt, TIMEOUT_CYC); end
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b111) begin n_fail++; $display("FAIL tmo_rsp: got %b expected 111", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}); end
        cyc();
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_err, bus.o_req_rdy} !== 3'b011) begin n_fail++; $display("FAIL tmo_after: got %b expected 011", {bus.o_rsp_vld, bus.o_rsp_err, bus.o_req_rdy}); end
    endtask

    task automatic test_reset_mid_burst();
        issue(1'b0, 40'h7000, 3'd4, '0, '0);
        cyc();
        cyc();
        bus.i_ext_mmu_rdat = pb[0];
        cyc();
        bus.i_ext_mmu_rdat = pb[1];
        n_chk++; if (ctl !== 5'b10000) begin n_fail++; $display("FAIL mid_beat2: got %b expected 10000", ctl); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (bus.o_req_rdy !== 1'b1 || ctl !== 5'b00000) begin n_fail++; $display("FAIL mid_rst_ctl: got rdy=%b ctl=%b expected 1/00000", bus.o_req_rdy, ctl); end
        n_chk++; if ({bus.o_mem_ext_burst_size, bus.o_mem_ext_paddr, bus.o_mem_ext_wdat, bus.o_mem_ext_mask} !== 187'd0) begin n_fail++; $display("FAIL mid_rst_bus: got size=%0d paddr=%h expected 0/0", bus.o_mem_ext_burst_size, bus.o_mem_ext_paddr); end
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b000 || bus.o_rsp_rdat !== 512'd0) begin n_fail++; $display("FAIL mid_rst_rsp: got %b rdat=%h expected 000/0", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}, bus.o_rsp_rdat); end
        cyc();
        cyc();
        n_chk++; if (bus.o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got %b expected 0", bus.o_rsp_vld); end
        rst_n = 1'b1;
        bus.i_ext_mmu_rdat = '0;
        cyc();
        issue(1'b0, 40'h8000, 3'd2, '0, '0);
        cyc();
        n_chk++; if (ctl !== 5'b11001 || bus.o_mem_ext_paddr !== 40'h8000) begin n_fail++; $display("FAIL post_start: got ctl=%b paddr=%h expected 11001/8000", ctl, bus.o_mem_ext_paddr); end
        cyc();
        bus.i_ext_mmu_rdat = pc[0];
        cyc();
        bus.i_ext_mmu_rdat = pc[1];
        n_chk++; if (ctl !== 5'b00100) begin n_fail++; $display("FAIL post_end: got %b expected 00100", ctl); end
        cyc();
        bus.i_ext_mmu_rdat = '0;
        bus.i_ext_mmu_rd_ack = 1'b1;
        cyc();
        bus.i_ext_mmu_rd_ack = 1'b0;
        n_chk++; if ({bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err} !== 3'b100 || bus.o_rsp_rdat !== {256'd0, pc[1], pc[0]}) begin n_fail++; $display("FAIL post_line: got %b rdat=%h expected 100/%h", {bus.o_rsp_vld, bus.o_rsp_wr, bus.o_rsp_err}, bus.o_rsp_rdat, {256'd0, pc[1], pc[0]}); end
        cyc();
    endtask

    initial begin
        bus.i_req_vld        = 1'b0;
        bus.i_req_wr         = 1'b0;
        bus.i_req_paddr      = '0;
        bus.i_req_beats      = 3'd0;
        bus.i_req_wdat       = '0;
        bus.i_req_mask       = '0;
        bus.i_ext_mmu_rdy    = 1'b1;
        bus.i_ext_mmu_rd_ack = 1'b0;
        bus.i_ext_mmu_wr_ack = 1'b0;
        bus.i_ext_mmu_rdat   = '0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_short_and_default();
        test_rdy_stall();
        test_timeout();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
